// File: rtl/ysyx_220066_mdu_iter.sv
// ysyx_220066_mdu_iter: iterative RV64M/RV32M multiply/divide unit.
//   Unsigned shift-add multiply and restoring divide on operand magnitudes.
//   Both consume one operand bit per cycle, MSB first, with a final sign-fix cycle.
//   Divide by zero and signed overflow are resolved when the op is accepted.
//   Optional feature: define MDU_EARLY_OUT_EN to end an op early once the remaining
//   operand bits cannot change the result. Left undefined, every normal op has a
//   fixed latency of N+1.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 kill the current op and return to idle
//   in_valid/in_ready     operand handshake; in_ready is high only in idle
//   op[3:0]               funct3 in op[2:0]; op[3] selects the W form (XLEN==64 only)
//   src_a, src_b          rs1, rs2
//   out_valid/out_ready   result handshake; out_valid is high only in done
//   out_result            result, held while out_valid & ~out_ready
module ysyx_220066_mdu_iter #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    localparam int unsigned PW = 2 * XLEN;
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] N_FULL = CW'(XLEN);
    localparam logic [CW-1:0] N_W    = CW'(32);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [2:0]      fn;
    logic            w_r;
    logic            spec_r;
    logic            neg_hi;
    logic            neg_lo;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;

    // Sign-extend the low word to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // W results are always the sign extension of bit 31.
    function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] v, input logic w);
        return w ? sext32(v[31:0]) : v;
    endfunction

    // Operand preparation and special-case detection for the op being offered.
    logic            accept;
    logic            w_op;
    logic            is_div;
    logic            sgn_a;
    logic            sgn_b;
    logic            neg_a;
    logic            neg_b;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] min_int;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] lo_init;
    logic [CW-1:0]   n_op;

    always_comb begin
        accept   = in_valid && (state == S_IDLE) && !flush;
        w_op     = (XLEN == 64) && op[3];
        is_div   = op[2];
        sgn_a    = (op[2:0] == 3'd1) || (op[2:0] == 3'd2) || (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
        sgn_b    = (op[2:0] == 3'd1) || (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
        a_ext    = src_a;
        b_ext    = src_b;
        if (w_op) begin
            a_ext = sgn_a ? sext32(src_a[31:0]) : XLEN'(src_a[31:0]);
            b_ext = sgn_b ? sext32(src_b[31:0]) : XLEN'(src_b[31:0]);
        end
        neg_a    = sgn_a && a_ext[XLEN-1];
        neg_b    = sgn_b && b_ext[XLEN-1];
        mag_a    = neg_a ? -a_ext : a_ext;
        mag_b    = neg_b ? -b_ext : b_ext;
        min_int  = w_op ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div && (b_ext == '0);
        div_ovf  = is_div && !op[0] && (a_ext == min_int) && (b_ext == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            spec_res = op[1] ? a_ext : '1;
        end else begin
            spec_res = op[1] ? '0 : min_int;
        end
        // Multiplier (mul) or dividend (div) is consumed MSB first from the top of lo.
        lo_init  = is_div ? mag_a : mag_b;
        if (w_op) begin
            lo_init = lo_init << (XLEN - 32);
        end
        n_op     = w_op ? N_W : N_FULL;
    end

    // One iteration step and the final sign fix.
    logic [CW-1:0]   last;
    logic [PW-1:0]   mul_acc;
    logic [XLEN:0]   div_sh;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [PW-1:0]   prod_s;
    logic [XLEN-1:0] quo_s;
    logic [XLEN-1:0] rem_s;
    logic [XLEN-1:0] fin_raw;
    logic [XLEN-1:0] fin_res;

    always_comb begin
        last     = w_r ? N_W : N_FULL;
        mul_acc  = {acc[PW-2:0], 1'b0} + (lo[XLEN-1] ? PW'(opnd) : '0);
        div_sh   = {acc[XLEN-1:0], lo[XLEN-1]};
        div_diff = div_sh - {1'b0, opnd};
        // Partial remainder stays below the divisor, so the top bit is a pure borrow.
        div_ge   = !div_diff[XLEN];
        prod_s   = neg_hi ? -acc : acc;
        quo_s    = neg_hi ? -lo : lo;
        rem_s    = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        if (!fn[2]) begin
            fin_raw = (fn[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
        end else begin
            fin_raw = fn[1] ? rem_s : quo_s;
        end
        fin_res  = wfix(fin_raw, w_r);
    end

`ifdef MDU_EARLY_OUT_EN
    // Early exit: no multiplier bits left, or no dividend bits left with a zero
    // partial remainder (all further quotient bits are then zero).
    logic [CW-1:0] left;
    logic          early;

    always_comb begin
        left = last - cnt;
        if (fn[2]) begin
            early = (acc[XLEN-1:0] == '0) && ((lo >> (CW'(XLEN) - left)) == '0);
        end else begin
            early = (lo == '0);
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = S_BUSY;
            S_BUSY: if (cnt == last) state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
        end
    end

    // State register and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == S_IDLE);
            out_valid <= (state_next == S_DONE);
        end
    end

    // Datapath. Special cases park their result at accept and spend one BUSY
    // cycle with the counter preset to its end value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fn         <= '0;
            w_r        <= 1'b0;
            spec_r     <= 1'b0;
            neg_hi     <= 1'b0;
            neg_lo     <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            lo         <= '0;
            opnd       <= '0;
            out_result <= '0;
        end else if (accept) begin
            fn     <= op[2:0];
            w_r    <= w_op;
            spec_r <= special;
            neg_hi <= neg_a ^ neg_b;
            neg_lo <= neg_a;
            cnt    <= special ? n_op : '0;
            acc    <= '0;
            lo     <= lo_init;
            opnd   <= is_div ? mag_b : mag_a;
            if (special) begin
                out_result <= wfix(spec_res, w_op);
            end
        end else if ((state == S_BUSY) && !flush) begin
            if (cnt == last) begin
                if (!spec_r) begin
                    out_result <= fin_res;
                end
`ifdef MDU_EARLY_OUT_EN
            end else if (early) begin
                if (fn[2]) begin
                    lo <= lo << left;
                end else begin
                    acc <= acc << left;
                end
                cnt <= last;
`endif
            end else begin
                if (fn[2]) begin
                    acc <= {{XLEN{1'b0}}, div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]};
                    lo  <= {lo[XLEN-2:0], div_ge};
                end else begin
                    acc <= mul_acc;
                    lo  <= {lo[XLEN-2:0], 1'b0};
                end
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_220066_mdu_iter.sv
// Directed bench for ysyx_220066_mdu_iter (XLEN=64): results, latencies,
// special cases, output hold, flush and asynchronous reset mid-op.
module tb_ysyx_220066_mdu_iter;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_220066_mdu_iter #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, measure edges from accept to out_valid, optionally stall
    // the consumer for 'hold' cycles, then pop the result.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp,
                          input int exp_lat, input int hold);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 200) begin
            step();
            guard++;
        end
        check({tag, " ready_before"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        step();
        in_valid = 1'b0;
        check({tag, " ready_after_accept"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, out_result, exp);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, " hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold_result"}, out_result, exp);
            check({tag, " hold_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " popped_valid"}, 64'(out_valid), 64'd0);
        check({tag, " popped_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int hits;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'd0;
        src_a     = '0;
        src_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_result", out_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Multiplies
        run_op("MUL",    4'b0000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
        run_op("MULHU",  4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        run_op("MULH",   4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, 0);
        run_op("MULHSU", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run_op("MULW",   4'b1000, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);

        // Divide special cases
        run_op("DIV0",   4'b0100, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run_op("REM0",   4'b0110, 64'd5, 64'd0, 64'd5, 1, 0);
        run_op("DIVOVF", 4'b0100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0);
        run_op("REMOVF", 4'b0110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);

        // Regular and W divides
        run_op("DIVW",   4'b1100, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
        run_op("REMW",   4'b1110, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
        run_op("DIV_hold", 4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 5);

        // Flush 10 cycles into a DIVU
        in_valid = 1'b1;
        op       = 4'b0101;
        src_a    = 64'd1000;
        src_b    = 64'd3;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush in_ready", 64'(in_ready), 64'd1);
        check("flush out_valid", 64'(out_valid), 64'd0);
        hits = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (out_valid) hits++;
        end
        check("flush no_result", 64'(hits), 64'd0);
        run_op("MUL_after_flush", 4'b0000, 64'd3, 64'd4, 64'd12, 65, 0);

        // Asynchronous reset in the middle of a multiply
        in_valid = 1'b1;
        op       = 4'b0011;
        src_a    = 64'd9;
        src_b    = 64'd9;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset in_ready", 64'(in_ready), 64'd1);
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset out_result", out_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_op("DIVU", 4'b0101, 64'd100, 64'd7, 64'd14, 65, 0);
        run_op("REMU", 4'b0111, 64'd100, 64'd7, 64'd2, 65, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
